// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
// KEY_MAP is indexed [row][col] and matches the printed legend of the keypad.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } scan_state_t;

    localparam int MAX_DIGITS = 8;

    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Active-low one-hot pattern; used for both column drive and the expected row image.
    function automatic logic [3:0] onehot_low(input logic [1:0] idx);
        onehot_low = ~(4'b0001 << idx);
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        single_low = ($countones(~rows) == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        low_index = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) low_index = 2'(i);
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divide-by-DIV counter producing a one-clock enable pulse.
// The pulse is high while the counter sits at its terminal value DIV-1.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, per-key debounce, and a 32-bit digit entry
// register in display nibble order (newest digit in [3:0]).
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] number,
    output logic [3:0]  digit_count
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic              tick;
    logic [3:0]        row_meta, row_sync;
    scan_state_t       state, state_nxt;
    logic [1:0]        col, col_nxt;
    logic [1:0]        lrow, lrow_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;
    logic [3:0]        accept_code;

    tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Rows idle high, so the synchroniser resets to "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
            col   <= 2'd0;
            lrow  <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            lrow  <= lrow_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // In DEBOUNCE and HOLD the column is frozen, so cnt counts consecutive ticks of one
    // observation: matching presses in DEBOUNCE, all-released ticks in HOLD.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        lrow_nxt  = lrow;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_low(row_sync)) begin
                        lrow_nxt = low_index(row_sync);
                        if (DEBOUNCE_SCANS == 1) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        col_nxt = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_sync == onehot_low(lrow)) begin
                        if (cnt == CNT_LAST) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt   = '0;
                        col_nxt   = col + 2'd1;
                        state_nxt = SCAN;
                    end
                end
                HOLD: begin
                    if (row_sync == 4'b1111) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt   = '0;
                            col_nxt   = col + 2'd1;
                            state_nxt = SCAN;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    assign accept_code = KEY_MAP[lrow_nxt][col];
    assign col_out     = onehot_low(col);

    // Clear owns the entry register, but an accept in the same clock still reports its key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            number      <= 32'h0;
            digit_count <= 4'd0;
        end else begin
            key_valid <= accept;
            if (accept)
                key_code <= accept_code;
            if (clear) begin
                number      <= 32'h0;
                digit_count <= 4'd0;
            end else if (accept) begin
                number <= {number[27:0], accept_code};
                if (digit_count < 4'(MAX_DIGITS))
                    digit_count <= digit_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a key-matrix model drives the rows from col_out, and a
// digit-entry model checks number/digit_count/key_code every clock.
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] number;
    logic [3:0]  digit_count;

    logic [3:0][3:0] pressed;   // pressed[row][col]
    logic [3:0]      kmap [16];
    logic [3:0]      exp_q [$];
    logic            clr_s;
    int              checks   = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    hex_keypad_scanner #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .clear(clear),
        .key_valid(key_valid), .key_code(key_code), .number(number),
        .digit_count(digit_count)
    );

    // Passive matrix: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(pressed[r] & ~col_out);
    end

    always @(posedge clk) clr_s <= clear;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entry model: each reported key is the next one the stimulus pressed.
    initial begin : model
        logic [31:0] m_num;
        logic [3:0]  m_cnt, m_code, code;
        m_num = 0; m_cnt = 0; m_code = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_num = 0; m_cnt = 0; m_code = 0;
                chk("rst_col", 32'(col_out), 32'hE);
                chk("rst_kv", 32'(key_valid), 32'd0);
            end else begin
                if (key_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_kv", 32'(key_code), 32'hFFFF);
                    end else begin
                        code   = exp_q.pop_front();
                        m_code = code;
                        if (!clr_s) begin
                            m_num = {m_num[27:0], code};
                            if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1;
                        end
                    end
                end
                if (clr_s) begin
                    m_num = 0; m_cnt = 0;
                end
            end
            chk("col_onehot", 32'($countones(~col_out)), 32'd1);
            chk("key_code", 32'(key_code), 32'(m_code));
            chk("number", number, m_num);
            chk("digit_count", 32'(digit_count), 32'(m_cnt));
        end
    end

    // Returns at the first negedge of a fresh dwell on column c.
    task automatic wait_col(input int c);
        int n = 0;
        logic [3:0] want;
        want = ~(4'b0001 << c);
        while (col_out == want && n < 100) begin @(negedge clk); n++; end
        while (col_out != want && n < 200) begin @(negedge clk); n++; end
        chk("wait_col", 32'(col_out), 32'(want));
    endtask

    task automatic press_key(input int r, input int c, input int hold, input string name);
        int kv_at = -1;
        wait_col(c);
        exp_q.push_back(kmap[r*4+c]);
        pressed[r][c] = 1'b1;
        for (int n = 1; n <= hold; n++) begin
            @(negedge clk);
            if (key_valid && kv_at < 0) kv_at = n;
        end
        pressed[r][c] = 1'b0;
        repeat (60) @(negedge clk);
        chk(name, 32'(kv_at), 32'd40);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t3r [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        int t3c [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic [3:0] exp_col [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int kv_at;
        kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        rst_n = 1'b0; clear = 1'b0; pressed = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: idle column walk, one step per 10 clocks.
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n % 10 == 5) chk("t1_col", 32'(col_out), 32'(exp_col[(n / 10) % 4]));
        end

        // 2: single key held for 10 ticks -> one accept of '6'.
        press_key(1, 2, 100, "t2_latency");
        chk("t2_number", number, 32'h6);
        chk("t2_count", 32'(digit_count), 32'd1);
        chk("t2_code", 32'(key_code), 32'h6);

        // 3: nine digits, oldest shifted out.
        for (int k = 0; k < 9; k++) press_key(t3r[k], t3c[k], 50, "t3_latency");
        chk("t3_number", number, 32'h23A456B7);
        chk("t3_count", 32'(digit_count), 32'd8);

        // 4: bounce on key '5' and two rows low together -> nothing accepted.
        wait_col(1);
        pressed[1][1] = 1'b1; repeat (20) @(negedge clk); pressed[1][1] = 1'b0;
        wait_col(1);
        pressed[1][1] = 1'b1; repeat (20) @(negedge clk); pressed[1][1] = 1'b0;
        repeat (60) @(negedge clk);
        wait_col(0);
        pressed[0][0] = 1'b1; pressed[3][0] = 1'b1;
        repeat (60) @(negedge clk);
        pressed = '0;
        repeat (60) @(negedge clk);
        wait_col(3);
        chk("t4_number", number, 32'h23A456B7);
        chk("t4_queue", 32'(exp_q.size()), 32'd0);

        // 5: clear, enter 1,2, then clear coincident with the accept of '9'.
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        press_key(0, 0, 50, "t5_latency");
        press_key(0, 1, 50, "t5_latency");
        chk("t5_number12", number, 32'h12);
        wait_col(2);
        exp_q.push_back(4'h9);
        pressed[2][2] = 1'b1;
        repeat (39) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t5_kv", 32'(key_valid), 32'd1);
        chk("t5_code", 32'(key_code), 32'h9);
        chk("t5_number", number, 32'h0);
        chk("t5_count", 32'(digit_count), 32'd0);
        repeat (20) @(negedge clk);
        pressed[2][2] = 1'b0;
        repeat (60) @(negedge clk);

        // 6: reset during debounce of '0' with the key still held.
        press_key(3, 2, 50, "t6_pre_latency");
        chk("t6_pre_number", number, 32'hF);
        wait_col(1);
        exp_q.push_back(4'h0);
        pressed[3][1] = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_col", 32'(col_out), 32'hE);
        chk("t6_rst_code", 32'(key_code), 32'h0);
        chk("t6_rst_number", number, 32'h0);
        chk("t6_rst_count", 32'(digit_count), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        kv_at = -1;
        for (int n = 1; n <= 200 && kv_at < 0; n++) begin
            @(negedge clk);
            if (key_valid) kv_at = n;
        end
        chk("t6_latency", 32'(kv_at), 32'd50);
        pressed[3][1] = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_count", 32'(digit_count), 32'd1);
        chk("t6_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
